// File: rtl/cg_pkg.sv
// Shared types and default parameters for the clock-gating controller.
// Auto-idle gating is built only when CG_AUTO_IDLE_EN is defined.
package cg_pkg;

    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2
    } cg_state_e;

    localparam int CG_NUM_CH_DEF      = 4;
    localparam int CG_IDLE_W_DEF      = 8;
    localparam int CG_WAKE_CYCLES_DEF = 2;

endpackage

// File: rtl/cg_channel_fsm.sv
// One gated-clock channel: OFF/WAKE/ON FSM, wake handshake, and the optional
// idle-timeout auto-gate (compiled in with CG_AUTO_IDLE_EN).
module cg_channel_fsm
    import cg_pkg::*;
#(
    parameter int IDLE_W      = CG_IDLE_W_DEF,
    parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_en,
    input  logic              wake_req,
    input  logic              busy,
    input  logic [IDLE_W-1:0] idle_thresh,
    output logic              ce,
    output logic              wake_ack
);

    localparam int WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAKE_CYCLES - 1);

    cg_state_e         state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              wake_req_q;
    logic              on_ack_q, on_ack_nxt;
    logic              idle_hit;

`ifdef CG_AUTO_IDLE_EN
    logic [IDLE_W-1:0] icnt, icnt_nxt, icnt_inc;

    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Compare the value the counter is about to take so the gate lands N+1 cycles after the last busy cycle
    assign icnt_inc = sat_inc(icnt);
    assign idle_hit = (idle_thresh != '0) && !(busy || wake_req) && (icnt_inc == idle_thresh);

    always_comb begin
        icnt_nxt = icnt_inc;
        if (state != CG_ON || state_nxt != CG_ON || busy || wake_req)
            icnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) icnt <= '0;
        else        icnt <= icnt_nxt;
    end
`else
    logic unused_idle;
    assign idle_hit    = 1'b0;
    assign unused_idle = ^idle_thresh;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CG_OFF;
            wcnt       <= '0;
            wake_req_q <= 1'b0;
            on_ack_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wcnt       <= wcnt_nxt;
            wake_req_q <= wake_req;
            on_ack_q   <= on_ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            CG_OFF: begin
                if (req_en && (wake_req || busy)) begin
                    state_nxt = CG_WAKE;
                    wcnt_nxt  = WCNT_LOAD;
                end
            end
            CG_WAKE: begin
                if (!req_en)            state_nxt = CG_OFF;
                else if (wcnt == '0)    state_nxt = CG_ON;
                else                    wcnt_nxt  = wcnt - 1'b1;
            end
            CG_ON: begin
                if (!req_en || idle_hit) state_nxt = CG_OFF;
            end
            default: state_nxt = CG_OFF;
        endcase
        // A request edge while settled in ON is acknowledged one cycle later
        on_ack_nxt = (state == CG_ON) && (state_nxt == CG_ON) && wake_req && !wake_req_q;
    end

    // The wake acknowledge coincides with the final WAKE cycle, whose edge enters ON
    always_comb begin
        ce       = (state != CG_OFF);
        wake_ack = on_ack_q;
        if (state == CG_WAKE && wcnt == '0 && req_en)
            wake_ack = 1'b1;
    end

endmodule

// File: rtl/soc_clock_gate_ctrl.sv
// Multi-channel clock-gating controller: one FSM and one BUFGCE-style gate per domain.
// Define CG_AUTO_IDLE_EN to enable the per-channel idle-timeout auto-gate.
module soc_clock_gate_ctrl
    import cg_pkg::*;
#(
    parameter int NUM_CH      = CG_NUM_CH_DEF,
    parameter int IDLE_W      = CG_IDLE_W_DEF,
    parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              scan_cg_en_i,
    input  logic [NUM_CH-1:0] req_en_i,
    input  logic [NUM_CH-1:0] wake_req_i,
    output logic [NUM_CH-1:0] wake_ack_o,
    input  logic [NUM_CH-1:0] busy_i,
    input  logic [IDLE_W-1:0] idle_thresh_i,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] gated_o
);

    logic [NUM_CH-1:0] ce;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic en_q;

        cg_channel_fsm #(
            .IDLE_W      (IDLE_W),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_fsm (
            .clk         (clk_i),
            .rst_n       (rst_ni),
            .req_en      (req_en_i[g]),
            .wake_req    (wake_req_i[g]),
            .busy        (busy_i[g]),
            .idle_thresh (idle_thresh_i),
            .ce          (ce[g]),
            .wake_ack    (wake_ack_o[g])
        );

        // Synchronous-CE buffer: enable captured while the root clock is low, so the output never glitches
        always_ff @(negedge clk_i or negedge rst_ni) begin
            if (!rst_ni) en_q <= 1'b0;
            else         en_q <= ce[g] | scan_cg_en_i;
        end

        assign clk_o[g] = clk_i & en_q;
    end

    assign gated_o = ~ce;

endmodule

// File: tb/tb_soc_clock_gate_ctrl.sv
// Self-checking bench for soc_clock_gate_ctrl (NUM_CH=4, WAKE_CYCLES=2).
// Idle-timeout expectations follow whether CG_AUTO_IDLE_EN is defined.
`timescale 1ns/1ps
module tb_soc_clock_gate_ctrl;

`ifdef CG_AUTO_IDLE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan = 1'b0;
    logic [3:0] req_en = 4'h0;
    logic [3:0] wake_req = 4'h0;
    logic [3:0] busy = 4'h0;
    logic [7:0] thresh = 8'h0;
    logic [3:0] wake_ack, clk_g, gated;

    always #5 clk = ~clk;

    soc_clock_gate_ctrl #(
        .NUM_CH      (4),
        .IDLE_W      (8),
        .WAKE_CYCLES (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .scan_cg_en_i  (scan),
        .req_en_i      (req_en),
        .wake_req_i    (wake_req),
        .wake_ack_o    (wake_ack),
        .busy_i        (busy),
        .idle_thresh_i (thresh),
        .clk_o         (clk_g),
        .gated_o       (gated)
    );

    typedef struct {
        string      name;
        logic [3:0] g;
        logic [3:0] a;
        logic [3:0] c;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] r;
        logic [3:0] w;
        logic [3:0] b;
        logic [3:0] eg;
        logic [3:0] ea;
    } vec_t;

    exp_t       sb[$];
    vec_t       tbl[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] prev_g = 4'hF;
    logic       prev_scan = 1'b0;
    logic [3:0] clk_hi;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outputs are sampled mid-cycle: clk_o in the high phase, the rest at the falling edge
    always begin
        @(posedge clk);
        #3;
        clk_hi = clk_g;
        @(negedge clk);
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".gated"}, gated, e.g);
            chk({e.name, ".ack"}, wake_ack, e.a);
            chk({e.name, ".clk"}, clk_hi, e.c);
        end
    end

    // One cycle of stimulus; the gate passes the clock one cycle after the enable is seen
    task automatic cyc(input string name, input logic [3:0] r, input logic [3:0] w,
                       input logic [3:0] b, input logic [7:0] th, input logic sc,
                       input logic [3:0] eg, input logic [3:0] ea);
        exp_t e;
        req_en   = r;
        wake_req = w;
        busy     = b;
        thresh   = th;
        scan     = sc;
        e.name   = name;
        e.g      = eg;
        e.a      = ea;
        e.c      = ~prev_g | {4{prev_scan}};
        sb.push_back(e);
        prev_g    = eg;
        prev_scan = sc;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic [3:0] r, input logic [3:0] w,
                       input logic [3:0] b, input logic [3:0] eg, input logic [3:0] ea);
        vec_t v;
        v.name = name; v.r = r; v.w = w; v.b = b; v.eg = eg; v.ea = ea;
        tbl.push_back(v);
    endtask

    // Channel 1 woken by busy, then left idle; gate_k is the cycle (after last busy) it should gate
    task automatic idle_run(input string name, input logic [7:0] th, input int pulse_k, input int gate_k);
        bit gates;
        gates = AUTO && (th != 8'h0);
        cyc({name, "_up0"}, 4'h2, 4'h0, 4'h2, th, 1'b0, 4'hF, 4'h0);
        cyc({name, "_up1"}, 4'h2, 4'h0, 4'h2, th, 1'b0, 4'hD, 4'h0);
        cyc({name, "_up2"}, 4'h2, 4'h0, 4'h2, th, 1'b0, 4'hD, 4'h2);
        cyc({name, "_lastbusy"}, 4'h2, 4'h0, 4'h2, th, 1'b0, 4'hD, 4'h0);
        for (int k = 1; k <= gate_k; k++)
            cyc((k == gate_k) ? {name, "_gate"} : {name, "_hold"}, 4'h2, 4'h0,
                (k == pulse_k) ? 4'h2 : 4'h0, th, 1'b0,
                (k == gate_k && gates) ? 4'hF : 4'hD, 4'h0);
        cyc({name, "_dis"}, 4'h0, 4'h0, 4'h0, th, 1'b0, gates ? 4'hF : 4'hD, 4'h0);
        cyc({name, "_off"}, 4'h0, 4'h0, 4'h0, th, 1'b0, 4'hF, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        add("rst_idle",   4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
        add("no_en",      4'h0, 4'h1, 4'h0, 4'hF, 4'h0);
        add("wake_t",     4'h1, 4'h1, 4'h0, 4'hF, 4'h0);
        add("wake_t1",    4'h1, 4'h1, 4'h0, 4'hE, 4'h0);
        add("wake_ack",   4'h1, 4'h1, 4'h0, 4'hE, 4'h1);
        add("on",         4'h1, 4'h0, 4'h0, 4'hE, 4'h0);
        add("rereq",      4'h1, 4'h1, 4'h0, 4'hE, 4'h0);
        add("rereq_ack",  4'h1, 4'h1, 4'h0, 4'hE, 4'h1);
        add("rereq_once", 4'h1, 4'h1, 4'h0, 4'hE, 4'h0);
        add("rereq_rel",  4'h1, 4'h0, 4'h0, 4'hE, 4'h0);
        add("dis_t",      4'h0, 4'h0, 4'h0, 4'hE, 4'h0);
        add("dis_t1",     4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
        add("busy_wake",  4'h8, 4'h0, 4'h8, 4'hF, 4'h0);
        add("busy_wake1", 4'h8, 4'h0, 4'h0, 4'h7, 4'h0);
        add("busy_ack",   4'h8, 4'h0, 4'h0, 4'h7, 4'h8);
        add("busy_on",    4'h8, 4'h0, 4'h0, 4'h7, 4'h0);
        add("on_req",     4'h8, 4'h8, 4'h0, 4'h7, 4'h0);
        add("on_req_ack", 4'h8, 4'h8, 4'h0, 4'h7, 4'h8);
        add("dis3",       4'h0, 4'h0, 4'h0, 4'h7, 4'h0);
        add("off3",       4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
        add("multi",      4'h6, 4'h6, 4'h0, 4'hF, 4'h0);
        add("multi1",     4'h6, 4'h6, 4'h0, 4'h9, 4'h0);
        add("multi_ack",  4'h6, 4'h6, 4'h0, 4'h9, 4'h6);
        add("multi_on",   4'h6, 4'h0, 4'h0, 4'h9, 4'h0);
        add("drop2",      4'h2, 4'h0, 4'h0, 4'h9, 4'h0);
        add("drop2_1",    4'h2, 4'h0, 4'h0, 4'hD, 4'h0);
        add("drop1",      4'h0, 4'h0, 4'h0, 4'hD, 4'h0);
        add("all_off",    4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
        add("wd",         4'h1, 4'h1, 4'h0, 4'hF, 4'h0);
        add("wd1",        4'h1, 4'h1, 4'h0, 4'hE, 4'h0);
        add("wd_drop",    4'h0, 4'h1, 4'h0, 4'hE, 4'h0);
        add("wd_off",     4'h0, 4'h1, 4'h0, 4'hF, 4'h0);
        add("wd_quiet",   4'h0, 4'h0, 4'h0, 4'hF, 4'h0);

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset.gated", gated, 4'hF);
        chk("in_reset.ack", wake_ack, 4'h0);
        rst_n = 1'b1;

        foreach (tbl[i])
            cyc(tbl[i].name, tbl[i].r, tbl[i].w, tbl[i].b, 8'h0, 1'b0, tbl[i].eg, tbl[i].ea);

        idle_run("idle5",   8'd5, 0, 6);
        idle_run("idle5p",  8'd5, 3, 9);
        idle_run("idle3hit", 8'd3, 3, 7);
        idle_run("nothr",   8'd0, 0, 300);

        // Scan forces every gate open without touching status
        cyc("scan_on",   4'h0, 4'h0, 4'h0, 8'h0, 1'b1, 4'hF, 4'h0);
        cyc("scan_clk",  4'h0, 4'h0, 4'h0, 8'h0, 1'b1, 4'hF, 4'h0);
        cyc("scan_off",  4'h0, 4'h0, 4'h0, 8'h0, 1'b0, 4'hF, 4'h0);
        cyc("scan_flat", 4'h0, 4'h0, 4'h0, 8'h0, 1'b0, 4'hF, 4'h0);

        // Reset in the last WAKE cycle of channel 2
        cyc("r2_req",  4'h4, 4'h4, 4'h0, 8'h0, 1'b0, 4'hF, 4'h0);
        cyc("r2_wake", 4'h4, 4'h4, 4'h0, 8'h0, 1'b0, 4'hB, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("r2_async.gated", gated, 4'hF);
        chk("r2_async.ack", wake_ack, 4'h0);
        #2;
        chk("r2_async.clk", clk_g, 4'h0);
        wake_req = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        prev_g    = 4'hF;
        prev_scan = 1'b0;
        for (int k = 0; k < 4; k++)
            cyc("r2_after", 4'h4, 4'h0, 4'h0, 8'h0, 1'b0, 4'hF, 4'h0);

        @(negedge clk);
        #1;
        chk("sb_drain", 4'(sb.size()), 4'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
